// File: rtl/scan_sel_sequencer.sv
// Round-robin channel-select sequencer feeding the 2-to-4 one-hot decoder.
// Optional sweep counter output enabled by defining SCAN_SWEEP_COUNT_EN.
module scan_sel_sequencer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    en_mask,
  input  logic [DW-1:0] dwell,
  output logic [1:0]    sel,
  output logic          sel_valid,
  output logic          busy,
`ifdef SCAN_SWEEP_COUNT_EN
  output logic [15:0]   sweep_cnt,
`endif
  output logic          sweep_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q;
  logic [1:0]    sel_q;
  logic [DW-1:0] cnt_q;
  logic          valid_q, busy_q, sweep_q;
  logic [1:0]    first_d, nxt_d, probe;
  logic [DW-1:0] dwell_d;
`ifdef SCAN_SWEEP_COUNT_EN
  logic [15:0]   sweep_cnt_q;
`endif

  assign dwell_d = (dwell == '0) ? DW'(1) : dwell;

  // Searching from the farthest offset down lets the nearest hit win; offset 4
  // lands back on sel_q so a lone enabled channel reselects itself.
  always_comb begin
    first_d = 2'd0;
    nxt_d   = sel_q;
    probe   = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (en_mask[k]) first_d = 2'(k);
    for (int k = 4; k >= 1; k--) begin
      probe = sel_q + 2'(k);
      if (en_mask[probe]) nxt_d = probe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sweep_q <= 1'b0;
`ifdef SCAN_SWEEP_COUNT_EN
      sweep_cnt_q <= '0;
`endif
    end else begin
      sweep_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop && en_mask != 4'd0) begin
            state_q <= SCAN;
            sel_q   <= first_d;
            cnt_q   <= dwell_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
`ifdef SCAN_SWEEP_COUNT_EN
            sweep_cnt_q <= '0;
`endif
          end
        end
        SCAN: begin
          if (stop) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q == DW'(1)) begin
            if (en_mask == 4'd0) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              sel_q   <= nxt_d;
              cnt_q   <= dwell_d;
              sweep_q <= (nxt_d <= sel_q);
`ifdef SCAN_SWEEP_COUNT_EN
              if (nxt_d <= sel_q) sweep_cnt_q <= sweep_cnt_q + 16'd1;
`endif
            end
          end else begin
            cnt_q <= cnt_q - DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = valid_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_q;
`ifdef SCAN_SWEEP_COUNT_EN
  assign sweep_cnt  = sweep_cnt_q;
`endif

endmodule
